load_store_unit: RTL

- Sits directly downstream of the multi-cycle core's MEM state, between the core's data port (dAddress/dWriteData/dReadData, MemRead/MemWrite) and the word-wide synchronous DATA_MEMORY (we/addr/din/dout, 1-cycle read latency, no byte enables).
- Handles the RV32I load and store widths: LB/LH/LW/LBU/LHU and SB/SH/SW.
- Performs byte-lane extraction and sign/zero extension, checks alignment, and implements sub-word stores as read-modify-write.
- Gives the core a ready/done handshake so the MEM state can stall for a variable number of cycles.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_lane_align.sv | 42 ++++
 rtl/load_store_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 widths, FSM states
// and the accept-time legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LD_WAIT,
    LD_CAP,
    ST_WR,
    RMW_RD,
    RMW_MOD,
    RMW_WR,
    ERR
  } state_t;

  // Legal direction, legal width for that direction, natural alignment.
  function automatic logic req_legal(
    input logic       rd,
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ok;
    ok = 1'b1;
    if (rd == wr) begin
      ok = 1'b0;
    end else if (rd) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
    end else begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    if (f3[1:0] == 2'b01 && a[0]) ok = 1'b0;
    if (f3[1:0] == 2'b10 && a != 2'b00) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane extraction with sign/zero extension for loads, and lane
// merge of store data into a read word for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = word[{addr, 3'b000} +: 8];
  assign half_v = word[{addr[1], 4'b0000} +: 16];

  // Select and extend the addressed lane for loads.
  always_comb begin
    load_data = word;
    unique case (funct3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_BU:   load_data = {24'h0, byte_v};
      F3_HU:   load_data = {16'h0, half_v};
      default: load_data = word;
    endcase
  end

  // Overlay the low byte/half of the store data onto the addressed lane.
  always_comb begin
    merged = word;
    unique case (funct3)
      F3_B:    merged[{addr, 3'b000} +: 8] = wdata[7:0];
      F3_H:    merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit between the core MEM state and a word-wide sync RAM.
// Optional LSU_BOUNDS_CHECK_EN rejects addresses beyond the RAM range.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   dAddress,
  input  logic [XLEN-1:0]   dWriteData,
  output logic [XLEN-1:0]   dReadData,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [XLEN-1:0]   ram_din,
  input  logic [XLEN-1:0]   ram_dout
);

  state_t              state;
  logic [ADDR_W+1:0]   addr_q;
  logic [2:0]          f3_q;
  logic [XLEN-1:0]     data_q;
  logic [XLEN-1:0]     load_data;
  logic [XLEN-1:0]     merged;
  logic                legal;
  logic                oob;

  assign legal = req_legal(MemRead, MemWrite, funct3, dAddress[1:0]);

`ifdef LSU_BOUNDS_CHECK_EN
  assign oob = |dAddress[XLEN-1:ADDR_W+2];
`else
  logic unused_upper;
  assign unused_upper = |dAddress[XLEN-1:ADDR_W+2];
  assign oob = 1'b0;
`endif

  lsu_lane_align u_align (
    .word      (ram_dout),
    .addr      (addr_q[1:0]),
    .funct3    (f3_q),
    .wdata     (data_q),
    .load_data (load_data),
    .merged    (merged)
  );

  assign ready    = (state == IDLE);
  assign ram_we   = (state == ST_WR) || (state == RMW_WR);
  assign ram_addr = addr_q[ADDR_W+1:2];
  assign ram_din  = data_q;

  // Access sequencer: accept, RAM sequencing, completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      f3_q      <= '0;
      data_q    <= '0;
      dReadData <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            addr_q <= dAddress[ADDR_W+1:0];
            f3_q   <= funct3;
            data_q <= dWriteData;
            if (!legal || oob)      state <= ERR;
            else if (MemRead)       state <= LD_WAIT;
            else if (funct3 == F3_W) state <= ST_WR;
            else                    state <= RMW_RD;
          end
        end
        LD_WAIT: state <= LD_CAP;
        LD_CAP: begin
          dReadData <= load_data;
          done      <= 1'b1;
          state     <= IDLE;
        end
        ST_WR: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        RMW_RD: state <= RMW_MOD;
        RMW_MOD: begin
          data_q <= merged;
          state  <= RMW_WR;
        end
        RMW_WR: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        ERR: begin
          done  <= 1'b1;
          err   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
